// File: rtl/pkt_h.sv
// Shared packet-path types: priority width/type, drainer FSM states and
// a saturating 32-bit increment used by the statistics counters.
package pkt_h;

  localparam int PKT_PRIO_W = 3;

  typedef logic [PKT_PRIO_W-1:0] prio_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_BACKOFF
  } drain_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pkt_tok_bucket.sv
// Token bucket: a refill tick every REFILL_PERIOD cycles adds a token up to
// TOK_MAX; consume removes one. Tick and consume together cancel out.
module pkt_tok_bucket #(
  parameter int TOK_MAX       = 8,
  parameter int REFILL_PERIOD = 16,
  localparam int CW           = $clog2(TOK_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          consume,
  output logic          tokens_nz,
  output logic [CW-1:0] count
);

  localparam int RW = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;

  logic [RW-1:0] refill_timer;
  logic          refill_tick;
  logic          take;

  assign refill_tick = (refill_timer == RW'(REFILL_PERIOD - 1));
  assign tokens_nz   = (count != '0);
  // an empty bucket cannot be drawn below zero
  assign take        = consume && tokens_nz;

  always_ff @(posedge clk) begin
    if (!rst) begin
      refill_timer <= '0;
      count        <= CW'(TOK_MAX);
    end else begin
      refill_timer <= refill_tick ? '0 : refill_timer + 1'b1;
      if (refill_tick && !take) begin
        if (count != CW'(TOK_MAX)) count <= count + 1'b1;
      end else if (take && !refill_tick) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_prio_drainer.sv
// Drains the packet priority queue: paced dequeue requests with response
// timeout/backoff, a single-entry egress slot and per-priority dispatch counters.
module pkt_prio_drainer
  import pkt_h::*;
#(
  parameter int DWIDTH        = 64,
  parameter int PRIO_W        = 3,
  parameter int TOK_MAX       = 8,
  parameter int REFILL_PERIOD = 16,
  parameter int RESP_TIMEOUT  = 32,
  parameter int BACKOFF_CYC   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  output logic                         deq_en,
  input  logic                         deq_valid,
  input  logic [DWIDTH-1:0]            deq_data,
  input  logic [PRIO_W-1:0]            deq_prior,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DWIDTH-1:0]            out_addr,
  output logic [PRIO_W-1:0]            out_prior,
  input  logic [PRIO_W-1:0]            stat_sel,
  output logic [31:0]                  stat_cnt,
  output logic [15:0]                  timeout_cnt,
  output logic                         err_drop,
  output drain_state_t                 dbg_state,
  output logic [$clog2(TOK_MAX+1)-1:0] dbg_tokens
);

  localparam int NCNT = 1 << PRIO_W;
  localparam int WW   = $clog2(RESP_TIMEOUT + 1);
  localparam int BW   = $clog2(BACKOFF_CYC + 1);

  drain_state_t  state;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] backoff_cnt;
  logic [31:0]   dispatch_cnt [NCNT];
  logic          capture;
  logic          drop;
  logic          tokens_nz;

  // Egress handshake: the slot moves one entry when out_valid && out_ready are
  // both high at a clock edge; while out_valid && !out_ready the contents hold.
  // A response is captured whenever the slot is empty, whatever the state.
  assign capture   = deq_valid && !out_valid;
  assign drop      = deq_valid && out_valid;
  assign dbg_state = state;

  pkt_tok_bucket #(
    .TOK_MAX      (TOK_MAX),
    .REFILL_PERIOD(REFILL_PERIOD)
  ) u_tok (
    .clk      (clk),
    .rst      (rst),
    .consume  (capture),
    .tokens_nz(tokens_nz),
    .count    (dbg_tokens)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      deq_en      <= 1'b0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_prior   <= '0;
      wait_cnt    <= '0;
      backoff_cnt <= '0;
      timeout_cnt <= '0;
      err_drop    <= 1'b0;
      stat_cnt    <= '0;
      for (int i = 0; i < NCNT; i++) dispatch_cnt[i] <= '0;
    end else begin
      deq_en   <= 1'b0;
      stat_cnt <= dispatch_cnt[stat_sel];
      if (drop) err_drop <= 1'b1;
      if (capture) begin
        out_valid <= 1'b1;
        out_addr  <= deq_data;
        out_prior <= deq_prior;
        state     <= ST_HOLD;
      end else begin
        case (state)
          ST_IDLE: begin
            if (en && !out_valid && tokens_nz) begin
              state  <= ST_REQ;
              deq_en <= 1'b1;
            end
          end
          ST_REQ: begin
            state    <= ST_WAIT;
            wait_cnt <= WW'(1);
          end
          ST_WAIT: begin
            if (wait_cnt == WW'(RESP_TIMEOUT)) begin
              state       <= ST_BACKOFF;
              backoff_cnt <= BW'(1);
              if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          ST_HOLD: begin
            if (out_ready) begin
              out_valid               <= 1'b0;
              state                   <= ST_IDLE;
              dispatch_cnt[out_prior] <= sat_inc32(dispatch_cnt[out_prior]);
            end
          end
          ST_BACKOFF: begin
            if (backoff_cnt == BW'(BACKOFF_CYC)) state <= ST_IDLE;
            else backoff_cnt <= backoff_cnt + 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pkt_prio_drainer.sv
// Bench for pkt_prio_drainer: scenario tasks plus randomized traffic checked
// against an event-timing reference model of the drainer.
module tb_pkt_prio_drainer;
  import pkt_h::*;

  localparam int TOK_MAX       = 8;
  localparam int REFILL_PERIOD = 16;
  localparam int RESP_TIMEOUT  = 32;
  localparam int BACKOFF_CYC   = 8;
  localparam int NEVER         = 2147483647;

  // clock / reset / DUT
  logic         clk = 1'b0;
  logic         rst, en, deq_en, deq_valid, out_valid, out_ready, err_drop;
  logic [63:0]  deq_data, out_addr;
  logic [2:0]   deq_prior, out_prior, stat_sel;
  logic [31:0]  stat_cnt;
  logic [15:0]  timeout_cnt;
  drain_state_t dbg_state;
  logic [3:0]   dbg_tokens;

  always #5 clk = ~clk;

  pkt_prio_drainer #(
    .DWIDTH(64), .PRIO_W(3), .TOK_MAX(TOK_MAX), .REFILL_PERIOD(REFILL_PERIOD),
    .RESP_TIMEOUT(RESP_TIMEOUT), .BACKOFF_CYC(BACKOFF_CYC)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .deq_en(deq_en), .deq_valid(deq_valid),
    .deq_data(deq_data), .deq_prior(deq_prior), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_prior(out_prior),
    .stat_sel(stat_sel), .stat_cnt(stat_cnt), .timeout_cnt(timeout_cnt),
    .err_drop(err_drop), .dbg_state(dbg_state), .dbg_tokens(dbg_tokens)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: event times instead of states
  int          cyc = 0;
  int          m_idle_at, m_timeout_at, m_base, m_tok;
  bit          m_full, m_err, m_deq_en;
  logic [63:0] m_addr;
  logic [2:0]  m_prio;
  logic [31:0] m_stat;
  logic [15:0] m_tmo;
  logic [31:0] m_cnt [8];

  task automatic model_advance();
    bit cap, tick;
    int t0;
    if (!rst) begin
      m_full = 0; m_err = 0; m_deq_en = 0; m_addr = '0; m_prio = '0;
      m_stat = '0; m_tmo = '0; m_tok = TOK_MAX;
      for (int i = 0; i < 8; i++) m_cnt[i] = '0;
      m_idle_at = cyc + 1; m_timeout_at = -1; m_base = cyc + 1;
      cyc++;
      return;
    end
    t0       = m_tok;
    cap      = deq_valid && !m_full;
    tick     = ((cyc - m_base) % REFILL_PERIOD) == REFILL_PERIOD - 1;
    m_stat   = m_cnt[stat_sel];
    m_deq_en = 0;
    if (deq_valid && m_full) m_err = 1;
    m_tok = t0 + (tick ? 1 : 0) - ((cap && t0 > 0) ? 1 : 0);
    if (m_tok > TOK_MAX) m_tok = TOK_MAX;
    if (cap) begin
      m_full = 1; m_addr = deq_data; m_prio = deq_prior;
      m_timeout_at = -1; m_idle_at = NEVER;
    end else if (m_full && out_ready) begin
      if (m_cnt[m_prio] != '1) m_cnt[m_prio] = m_cnt[m_prio] + 32'd1;
      m_full = 0; m_idle_at = cyc + 1;
    end else if (m_timeout_at == cyc) begin
      if (m_tmo != '1) m_tmo = m_tmo + 16'd1;
      m_timeout_at = -1; m_idle_at = cyc + 1 + BACKOFF_CYC;
    end else if (m_idle_at == cyc) begin
      if (en && t0 > 0) begin
        m_deq_en = 1; m_timeout_at = cyc + 1 + RESP_TIMEOUT; m_idle_at = NEVER;
      end else begin
        m_idle_at = cyc + 1;
      end
    end
    cyc++;
  endtask

  // queue responder and cycle driver
  int resp_q[$];
  int lat_q[$];
  int lat_lo = 1, lat_hi = 1;
  bit no_answer = 0, fix_data = 0, rand_sel = 1;

  task automatic step();
    int lat;
    if (rst && deq_en === 1'b1 && !no_answer) begin
      lat = (lat_q.size() > 0) ? lat_q.pop_front() : int'($urandom_range(lat_hi, lat_lo));
      resp_q.push_back(cyc + lat);
      resp_q.sort();
    end
    deq_valid = 1'b0;
    while (resp_q.size() > 0 && resp_q[0] <= cyc) begin
      void'(resp_q.pop_front());
      deq_valid = 1'b1;
    end
    if (!rst) begin
      deq_valid = 1'b0;
      resp_q.delete();
    end
    deq_data  = fix_data ? 64'h1234 : {$urandom, $urandom};
    deq_prior = fix_data ? 3'd5 : 3'($urandom_range(7, 0));
    if (rand_sel) stat_sel = 3'($urandom_range(7, 0));
    model_advance();
    @(negedge clk);
  endtask

  function automatic logic [85:0] obs_vec();
    return {deq_en, out_valid, out_addr, out_prior, timeout_cnt, err_drop};
  endfunction

  function automatic logic [85:0] exp_vec();
    return {m_deq_en, m_full, m_addr, m_prio, m_tmo, m_err};
  endfunction

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; out_ready = 1'b0;
    lat_q.delete(); no_answer = 0; fix_data = 0; rand_sel = 1; lat_lo = 1; lat_hi = 1;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; out_ready = 1'b0;
    step(); step();
    n_checks++; if (deq_en !== 1'b0) $display("FAIL reset_deq_en got %b want 0", deq_en); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_addr !== 64'h0) $display("FAIL reset_out_addr got %h want 0", out_addr); else n_pass++;
    n_checks++; if (out_prior !== 3'd0) $display("FAIL reset_out_prior got %0d want 0", out_prior); else n_pass++;
    n_checks++; if (stat_cnt !== 32'd0) $display("FAIL reset_stat_cnt got %0d want 0", stat_cnt); else n_pass++;
    n_checks++; if (timeout_cnt !== 16'd0) $display("FAIL reset_timeout_cnt got %0d want 0", timeout_cnt); else n_pass++;
    n_checks++; if (err_drop !== 1'b0) $display("FAIL reset_err_drop got %b want 0", err_drop); else n_pass++;
    n_checks++; if (dbg_tokens !== 4'(TOK_MAX)) $display("FAIL reset_tokens got %0d want %0d", dbg_tokens, TOK_MAX); else n_pass++;
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int t;
    do_reset();
    en = 1'b1; out_ready = 1'b1; fix_data = 1;
    for (int k = 0; k < 20 && deq_en !== 1'b1; k++) step();
    n_checks++; if (deq_en !== 1'b1) $display("FAIL basic_wait_deq_en got %b want 1", deq_en); else n_pass++;
    en = 1'b0;
    t = cyc;
    step(); step();
    n_checks++; if (cyc - t != 2 || out_valid !== 1'b1) $display("FAIL basic_valid_t2 got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_addr !== 64'h1234) $display("FAIL basic_addr got %h want 1234", out_addr); else n_pass++;
    n_checks++; if (out_prior !== 3'd5) $display("FAIL basic_prior got %0d want 5", out_prior); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_valid_t3 got %b want 0", out_valid); else n_pass++;
    rand_sel = 0; stat_sel = 3'd5;
    step(); step();
    n_checks++; if (stat_cnt !== 32'd1) $display("FAIL basic_stat5 got %0d want 1", stat_cnt); else n_pass++;
    rand_sel = 1; fix_data = 0;
  endtask

  task automatic test_token_pacing();
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      step();
      n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL pacing_outputs cyc %0d got %h want %h", cyc, obs_vec(), exp_vec()); else n_pass++;
      n_checks++; if (dbg_tokens !== 4'(m_tok) || dbg_tokens > 4'(TOK_MAX)) $display("FAIL pacing_tokens cyc %0d got %0d want %0d", cyc, dbg_tokens, m_tok); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int t1, t2;
    do_reset();
    en = 1'b1; out_ready = 1'b1; no_answer = 1;
    for (int k = 0; k < 20 && deq_en !== 1'b1; k++) step();
    n_checks++; if (deq_en !== 1'b1) $display("FAIL timeout_wait_deq_en got %b want 1", deq_en); else n_pass++;
    t1 = cyc; t2 = -1;
    for (int k = 0; k < 60 && t2 < 0; k++) begin
      step();
      n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL timeout_outputs cyc %0d got %h want %h", cyc, obs_vec(), exp_vec()); else n_pass++;
      if (deq_en === 1'b1) t2 = cyc;
    end
    n_checks++; if (t2 - t1 != RESP_TIMEOUT + BACKOFF_CYC + 2) $display("FAIL timeout_req_gap got %0d want %0d", t2 - t1, RESP_TIMEOUT + BACKOFF_CYC + 2); else n_pass++;
    n_checks++; if (timeout_cnt !== 16'd1) $display("FAIL timeout_cnt got %0d want 1", timeout_cnt); else n_pass++;
    n_checks++; if (dbg_tokens !== 4'(TOK_MAX)) $display("FAIL timeout_tokens got %0d want %0d", dbg_tokens, TOK_MAX); else n_pass++;
  endtask

  task automatic test_late_response();
    do_reset();
    en = 1'b1; out_ready = 1'b0; lat_q.push_back(36);
    for (int k = 0; k < 20 && deq_en !== 1'b1; k++) step();
    for (int k = 0; k < 37; k++) begin
      step();
      n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL late_outputs cyc %0d got %h want %h", cyc, obs_vec(), exp_vec()); else n_pass++;
    end
    n_checks++; if (out_valid !== 1'b1 || dbg_state !== ST_HOLD) $display("FAIL late_capture got %b/%0d want 1/%0d", out_valid, dbg_state, ST_HOLD); else n_pass++;
    n_checks++; if (timeout_cnt !== 16'd1) $display("FAIL late_timeout_cnt got %0d want 1", timeout_cnt); else n_pass++;
    do_reset();
    en = 1'b1; out_ready = 1'b0; lat_q.push_back(43); lat_q.push_back(3);
    for (int k = 0; k < 20 && deq_en !== 1'b1; k++) step();
    for (int k = 0; k < 50; k++) begin
      step();
      n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL drop_outputs cyc %0d got %h want %h", cyc, obs_vec(), exp_vec()); else n_pass++;
    end
    n_checks++; if (err_drop !== 1'b1) $display("FAIL drop_err got %b want 1", err_drop); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL drop_slot got %b want 1", out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 10 && out_valid !== 1'b1; k++) step();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_wait_valid got %b want 1", out_valid); else n_pass++;
    for (int k = 0; k < 20; k++) begin
      step();
      n_checks++; if ({out_valid, deq_en, out_addr, out_prior} !== {1'b1, 1'b0, m_addr, m_prio}) $display("FAIL bp_hold cyc %0d got %b %b %h %0d want 1 0 %h %0d", cyc, out_valid, deq_en, out_addr, out_prior, m_addr, m_prio); else n_pass++;
    end
    out_ready = 1'b1; en = 1'b0;
    rand_sel = 0; stat_sel = m_prio;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_release got %b want 0", out_valid); else n_pass++;
    step(); step();
    n_checks++; if (stat_cnt !== 32'd1) $display("FAIL bp_single_transfer got %0d want 1", stat_cnt); else n_pass++;
    rand_sel = 1;
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 30; k++) step();
    out_ready = 1'b0;
    for (int k = 0; k < 10 && out_valid !== 1'b1; k++) step();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL rsthold_wait_valid got %b want 1", out_valid); else n_pass++;
    rst = 1'b0; en = 1'b0;
    step();
    rst = 1'b1;
    n_checks++; if (out_valid !== 1'b0 || out_addr !== 64'h0) $display("FAIL rsthold_slot got %b %h want 0 0", out_valid, out_addr); else n_pass++;
    n_checks++; if (dbg_tokens !== 4'(TOK_MAX)) $display("FAIL rsthold_tokens got %0d want %0d", dbg_tokens, TOK_MAX); else n_pass++;
    rand_sel = 0;
    for (int s = 0; s < 8; s++) begin
      stat_sel = 3'(s);
      step();
      n_checks++; if (stat_cnt !== 32'd0) $display("FAIL rsthold_cnt%0d got %0d want 0", s, stat_cnt); else n_pass++;
    end
    rand_sel = 1;
  endtask

  task automatic test_random();
    logic prev_deq;
    do_reset();
    lat_lo = 1; lat_hi = 45;
    prev_deq = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      en        = ($urandom_range(9, 0) < 8);
      out_ready = ($urandom_range(9, 0) < 7);
      if ($urandom_range(399, 0) == 0) rst = 1'b0;
      step();
      rst = 1'b1;
      n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL rand_outputs cyc %0d got %h want %h", cyc, obs_vec(), exp_vec()); else n_pass++;
      n_checks++; if (stat_cnt !== m_stat) $display("FAIL rand_stat cyc %0d got %0d want %0d", cyc, stat_cnt, m_stat); else n_pass++;
      n_checks++; if (dbg_tokens !== 4'(m_tok)) $display("FAIL rand_tokens cyc %0d got %0d want %0d", cyc, dbg_tokens, m_tok); else n_pass++;
      n_checks++; if (deq_en === 1'b1 && (prev_deq === 1'b1 || out_valid === 1'b1)) $display("FAIL rand_deq_rule cyc %0d got %b want 0", cyc, deq_en); else n_pass++;
      prev_deq = deq_en;
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; out_ready = 1'b0; deq_valid = 1'b0;
    deq_data = '0; deq_prior = '0; stat_sel = '0;
    test_reset();
    test_basic();
    test_token_pacing();
    test_timeout();
    test_late_response();
    test_backpressure();
    test_reset_mid_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pkt_prio_drainer.md
# pkt_prio_drainer

Downstream consumer of the packet priority queue (`pkt_Priorer`). It issues dequeue requests, captures the returned 64-bit buffer address and priority, and presents them on a single-entry valid/ready egress slot. Requests are paced by a token bucket and bounded by a response timeout with backoff. Per-priority dispatch counters are kept for debug readout.

## Interface
- `DWIDTH`, 64: address/data width returned by the queue
- `PRIO_W`, 3: priority width; 2^PRIO_W counters
- `TOK_MAX`, 8: token bucket depth
- `REFILL_PERIOD`, 16: cycles per +1 token (≥1)
- `RESP_TIMEOUT`, 32: max cycles waited for a dequeue response (≥1)
- `BACKOFF_CYC`, 8: idle cycles after a timeout (≥1)

- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  synchronous reset, active-low (0 = reset)
- `en`  in  1  enable new requests; in-flight work completes regardless
- `deq_en`  out  1  one-cycle dequeue request to the queue
- `deq_valid`  in  1  one-cycle response strobe from the queue
- `deq_data`  in  DWIDTH  returned buffer address
- `deq_prior`  in  PRIO_W  returned priority
- `out_valid`  out  1  egress slot full
- `out_ready`  in  1  egress consumer accepts
- `out_addr`  out  DWIDTH  slot address
- `out_prior`  out  PRIO_W  slot priority
- `stat_sel`  in  PRIO_W  counter select
- `stat_cnt`  out  32  selected dispatch counter, registered
- `timeout_cnt`  out  16  saturating timeout count
- `err_drop`  out  1  sticky: response arrived with slot full

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, BACKOFF.
- IDLE→REQ when `en`=1, slot empty, tokens>0.
- REQ: `deq_en`=1 for exactly this cycle → WAIT.
- WAIT: wait counter starts at 1 on entry and increments each cycle. `deq_valid` → HOLD. Counter==RESP_TIMEOUT with no `deq_valid` → BACKOFF, `timeout_cnt`+1 (saturates at 0xFFFF). When both happen in the same cycle, `deq_valid` wins.
- HOLD: `out_valid`=1. Data is stable until `out_ready`. On `out_valid`&`out_ready` → IDLE, and `stat_cnt[out_prior]`+1 (saturates at 2^32−1).
- BACKOFF: stay for BACKOFF_CYC cycles → IDLE.
- Capture rule: `deq_valid` with the slot empty is captured in any state, including late responses in BACKOFF/IDLE and a same-cycle response in REQ. Next state is HOLD.
- `deq_valid` with the slot full: data dropped, `err_drop` set (cleared only by reset), no token consumed, state unchanged.
- Token bucket: a token is consumed on capture, not on request, so timed-out requests cost nothing. A refill tick fires every REFILL_PERIOD cycles and saturates at TOK_MAX. A refill and a consume in the same cycle leave the count unchanged.
- `stat_cnt` = counter[`stat_sel`] registered; it reflects a same-cycle increment one cycle later.

## Timing
- Reset values: `deq_en`=0, `out_valid`=0, `out_addr`=0, `out_prior`=0, `stat_cnt`=0, `timeout_cnt`=0, `err_drop`=0. Internal: tokens=TOK_MAX, all counters 0, state IDLE, refill timer 0.
- Reset asserted mid-operation: all of the above reapply at the next edge, and any slot content is discarded.
- Best-case path: request at cycle t, response at t+1, `out_valid` at t+2. With `out_ready` held high, `out_valid` falls at t+3 and IDLE is reached at t+3. The next `deq_en` is at t+4.
- Maximum throughput: one entry per 4 cycles, further limited by tokens.
- `deq_en` never asserts in consecutive cycles and never asserts while the slot is full.

## Structure
- `pkt_h` gains `drain_state_t` (enum of the five states) and a `prio_t` typedef (logic [PRIO_W-1:0]) shared with `pkt_Priorer`'s `out_prior`.
- Sub-module `pkt_tok_bucket`: refill timer plus saturating token counter. Ports: consume, tokens_nz, count.
- FSM, slot, and statistics live in the top.

## Test plan
- Basic: reset, `en`=1, queue answers 1 cycle after `deq_en` with addr 0x1234, prior 5, `out_ready`=1 → `out_addr`=0x1234 at t+2; `stat_sel`=5 gives `stat_cnt`=1.
- Token pacing: TOK_MAX=2, REFILL_PERIOD=16, queue always answers → 2 dispatches back-to-back, then one per 16 cycles; tokens never exceed 2.
- Timeout: queue never answers → `deq_en` pulses, 32 WAIT cycles, `timeout_cnt`=1, 8 cycles silent, next `deq_en`; tokens stay at TOK_MAX.
- Late response: answer arrives in BACKOFF → captured, `out_valid`=1, then the next request's answer arrives while the slot is full → dropped, `err_drop`=1.
- Backpressure: `out_ready`=0 for 20 cycles → `out_addr`/`out_prior` stable, no `deq_en`; `out_ready`=1 → single transfer.
- Reset mid-HOLD: `rst`=0 one cycle while `out_valid`=1 → next cycle `out_valid`=0, counters 0, tokens=TOK_MAX.
